uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame.
REQ-002 SHALL have port clk, input, 1: oversampling clock at Prescale x bit rate; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port RX_IN, input, 1: serial line; idle high.
REQ-005 SHALL have port Prescale, input, 6: oversampling ratio; supported values 8, 16, 32; other values are unsupported and give undefined results.
REQ-006 SHALL have port Par_En, input, 1: 1 means a parity bit follows the data bits.
REQ-007 SHALL have port Par_Typ, input, 1: parity type; 0 = even, 1 = odd.
REQ-008 SHALL have port P_DATA, output, DATA_W: received byte, LSB received first.
REQ-009 SHALL have port Data_Valid, output, 1: frame received with no errors.
REQ-010 SHALL have port PAR_Err, output, 1: parity mismatch in the current frame.
REQ-011 SHALL have port STP_Err, output, 1: stop bit sampled as 0.

Function
REQ-012 SHALL use a frame of start(0), DATA_W data bits LSB-first, optional parity bit, then stop(1); each bit lasts Prescale clk cycles.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; an edge counter runs 0..Prescale-1 within each bit and a bit counter runs 0..DATA_W-1.
REQ-014 SHALL leave IDLE for START in the cycle RX_IN is sampled 0, with the edge counter at 0.
REQ-015 SHALL take each bit value as the majority of 3 samples at edge counts P/2-1, P/2, P/2+1, where P = Prescale; the decision is made at edge count P/2+2.
REQ-016 START: if the sampled value is 1 (glitch), SHALL return to IDLE at the decision point with no flags raised.
REQ-017 START: if the sampled value is 0, SHALL latch Par_En and Par_Typ for the frame, then enter DATA at the end of the bit.
REQ-018 DATA: SHALL shift each decided bit into the shift register MSB-side (right shift) so that bit 0 is received first; after DATA_W bits go to PARITY if Par_En is latched, else to STOP.
REQ-019 PARITY: expected bit is XOR-reduce of the data for even parity, or its inverse for odd; on mismatch SHALL set PAR_Err at the decision point.
REQ-020 STOP: if the sampled value is 0, SHALL set STP_Err at the decision point.
REQ-021 STOP: if no error occurred, Data_Valid SHALL be high from the cycle after the stop decision through edge count P-1 (2 cycles at P=8), with P_DATA stable throughout.
REQ-022 SHALL hold PAR_Err and STP_Err until the end of the stop bit; both clear on return to IDLE.
REQ-023 SHALL return to IDLE at edge count P-1 of STOP; back-to-back frames are accepted, starting the next frame if RX_IN is 0 in IDLE.
REQ-024 P_DATA SHALL hold its last value between frames.
REQ-025 Data_Valid, PAR_Err and STP_Err SHALL stay 0 while idle.
REQ-026 Data_Valid SHALL never be 1 in the same cycle as PAR_Err or STP_Err.

Reset
REQ-027 On rst, asynchronously: state IDLE; counters 0; P_DATA 0x00; Data_Valid, PAR_Err and STP_Err 0; latched parity config 0.
REQ-028 A reset mid-frame SHALL abort the frame with no flags raised.

Configuration
REQ-029 UART_RX_MAJORITY_EN defined: 3-sample majority vote per REQ-015.
REQ-030 UART_RX_MAJORITY_EN undefined: single sample at edge count P/2; decision timing unchanged.

Structure
REQ-031 Package uart_rx_pkg SHALL hold the FSM state enum typedef and the DATA_W default constant.
REQ-032 Sub-module uart_rx_sampler SHALL contain the edge counter and sample/majority logic and output the sampled bit plus a decision strobe; the FSM, shift register and parity check stay in uart_rx.

Verification
REQ-033 P=8, Par_En=1, Par_Typ=1, data 0xA5, parity 1, stop 1 -> Data_Valid=1, P_DATA=0xA5, PAR_Err=0, STP_Err=0.
REQ-034 P=8, Par_En=1, Par_Typ=0, data 0x3C, parity bit 1 (wrong) -> PAR_Err=1, Data_Valid=0.
REQ-035 P=8, Par_En=0, data 0x81, stop bit 0 -> STP_Err=1, Data_Valid=0; next frame 0x55 with correct start and stop bits -> Data_Valid=1, P_DATA=0x55.
REQ-036 RX_IN low for 3 clk cycles then high -> FSM returns to IDLE; no flags ever raised.
REQ-037 RX_IN held high for 800 clk cycles -> Data_Valid, PAR_Err and STP_Err stay 0.
REQ-038 P=16 and P=32, 100 random frames of random data, random Par_En/Par_Typ, no errors -> every frame Data_Valid=1 with matching P_DATA.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
//   UART_RX_DATA_W : default number of data bits per frame
//   PRESCALE_W     : width of the Prescale (oversampling ratio) input
//   rx_state_t     : receiver FSM state encoding
package uart_rx_pkg;

    localparam int unsigned UART_RX_DATA_W = 8;
    localparam int unsigned PRESCALE_W     = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and bit-value sampling for uart_rx.
//   clk, rst        : clock, asynchronous active-high reset
//   i_rx            : serial line (already synchronous to clk)
//   i_prescale      : oversampling ratio (8, 16 or 32)
//   i_run           : 1 while a frame is in progress; 0 holds the counter at 0
//   o_bit_c         : bit value, valid while o_decide_c is high
//   o_decide_c      : decision strobe; registered consumers see the result
//                     from edge count P/2+2 onward
//   o_last_c        : edge count is P-1 (last cycle of the bit)
// Build option UART_RX_MAJORITY_EN: 3-sample majority at P/2-1, P/2, P/2+1;
// otherwise a single sample taken at P/2. Decision timing is the same.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_run,
    output logic                  o_bit_c,
    output logic                  o_decide_c,
    output logic                  o_last_c
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] w_half;
    logic                  r_s1;

    assign w_half     = i_prescale >> 1;
    assign o_last_c   = (r_edge_cnt == i_prescale - PRESCALE_W'(1));
    // The third sample is the live line value, so the decision lands on the
    // edge that moves the counter to P/2+2.
    assign o_decide_c = (r_edge_cnt == w_half + PRESCALE_W'(1));

    // Edge counter: 0..P-1 within each bit, parked at 0 when not running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else if (!i_run || o_last_c) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end

    // Centre sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
        end else if (r_edge_cnt == w_half) begin
            r_s1 <= i_rx;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_s0;

    // Early sample for the majority vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b1;
        end else if (r_edge_cnt == w_half - PRESCALE_W'(1)) begin
            r_s0 <= i_rx;
        end
    end

    assign o_bit_c = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
`else
    assign o_bit_c = r_s1;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, frame = start, DATA_W data bits
// LSB-first, optional parity, stop.
//   clk        : oversampling clock (Prescale x bit rate)
//   rst        : asynchronous active-high reset
//   RX_IN      : serial line, idle high (assumed synchronous to clk)
//   Prescale   : oversampling ratio, 8/16/32
//   Par_En     : parity bit present (latched at start-bit decision)
//   Par_Typ    : 0 even, 1 odd (latched at start-bit decision)
//   P_DATA     : last correctly received word
//   Data_Valid : frame received without error (high through end of stop bit)
//   PAR_Err    : parity mismatch, held until end of stop bit
//   STP_Err    : stop bit sampled low, held until end of stop bit
// Build option UART_RX_MAJORITY_EN selects 3-sample majority in the sampler.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W = UART_RX_DATA_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_Err,
    output logic                  STP_Err
);

    localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    rx_state_t             r_state;
    rx_state_t             w_next_state;

    logic                  w_bit;
    logic                  w_decide;
    logic                  w_last;
    logic                  w_run;
    logic                  w_par_exp;

    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_d;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     w_shift_d;
    logic [DATA_W-1:0]     w_p_data_d;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  w_par_en_d;
    logic                  w_par_typ_d;
    logic                  w_data_valid_d;
    logic                  w_par_err_d;
    logic                  w_stp_err_d;

    // Counter runs only while a frame stays in progress, so it reads 0 in IDLE
    assign w_run     = (r_state != IDLE) && (w_next_state != IDLE);
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (RX_IN),
        .i_prescale (Prescale),
        .i_run      (w_run),
        .o_bit_c    (w_bit),
        .o_decide_c (w_decide),
        .o_last_c   (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_decide && w_bit) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_last && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_last) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_bit_cnt_d    = r_bit_cnt;
        w_shift_d      = r_shift;
        w_p_data_d     = P_DATA;
        w_par_en_d     = r_par_en;
        w_par_typ_d    = r_par_typ;
        w_data_valid_d = Data_Valid;
        w_par_err_d    = PAR_Err;
        w_stp_err_d    = STP_Err;
        case (r_state)
            START: begin
                if (w_decide && !w_bit) begin
                    w_par_en_d  = Par_En;
                    w_par_typ_d = Par_Typ;
                end
            end
            DATA: begin
                // Right shift: the first bit received ends up in bit 0
                if (w_decide) begin
                    w_shift_d = DATA_W'({w_bit, r_shift} >> 1);
                end
                if (w_last) begin
                    w_bit_cnt_d = (r_bit_cnt == LAST_BIT) ? '0
                                                          : r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            PARITY: begin
                if (w_decide && (w_bit != w_par_exp)) begin
                    w_par_err_d = 1'b1;
                end
            end
            STOP: begin
                if (w_decide) begin
                    if (!w_bit) begin
                        w_stp_err_d = 1'b1;
                    end else if (!PAR_Err) begin
                        w_data_valid_d = 1'b1;
                        w_p_data_d     = r_shift;
                    end
                end
            end
            default: ;
        endcase
        // Status flags never survive into IDLE
        if (w_next_state == IDLE) begin
            w_data_valid_d = 1'b0;
            w_par_err_d    = 1'b0;
            w_stp_err_d    = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            PAR_Err    <= 1'b0;
            STP_Err    <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_d;
            r_shift    <= w_shift_d;
            r_par_en   <= w_par_en_d;
            r_par_typ  <= w_par_typ_d;
            P_DATA     <= w_p_data_d;
            Data_Valid <= w_data_valid_d;
            PAR_Err    <= w_par_err_d;
            STP_Err    <= w_stp_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are driven bit by bit;
// a frame-level model predicts each frame's outcome, and a monitor groups the
// DUT's flag activity into one outcome per frame for comparison.
module tb_uart_rx;

    localparam int unsigned DATA_W = 8;

    typedef struct {
        logic       dv;
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         dv_len;
    } outcome_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              RX_IN;
    logic [5:0]        Prescale;
    logic              Par_En;
    logic              Par_Typ;
    logic [DATA_W-1:0] P_DATA;
    logic              Data_Valid;
    logic              PAR_Err;
    logic              STP_Err;

    outcome_t exp_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       n_episodes = 0;
    int       flag_cycles = 0;
    int       overlap_cnt = 0;
    int       unstable_cnt = 0;

    always #5 clk = ~clk;

    uart_rx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .Par_En     (Par_En),
        .Par_Typ    (Par_Typ),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_Err    (PAR_Err),
        .STP_Err    (STP_Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Frame outcome from the line-protocol rules
    function automatic outcome_t model(input logic [7:0] d, input logic pen, input logic ptyp,
                                       input logic pbit, input logic sbit, input int p);
        outcome_t o;
        int ones;
        ones     = $countones(d) + ((pen && pbit) ? 1 : 0);
        o.par    = pen && ((ones % 2) != (ptyp ? 1 : 0));
        o.stp    = !sbit;
        o.dv     = !o.par && !o.stp;
        o.data   = d;
        o.dv_len = o.dv ? (p - (p / 2 + 2)) : 0;
        return o;
    endfunction

    function automatic logic good_par(input logic [7:0] d, input logic ptyp);
        return logic'(($countones(d) + (ptyp ? 1 : 0)) % 2);
    endfunction

    // Monitor: one episode = contiguous run of any flag high
    logic       m_active = 1'b0;
    logic       m_dv, m_par, m_stp;
    logic [7:0] m_data;
    int         m_len;
    outcome_t   m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (Data_Valid || PAR_Err || STP_Err) begin
            flag_cycles++;
            if (Data_Valid && (PAR_Err || STP_Err)) overlap_cnt++;
            if (!m_active) begin
                m_active = 1'b1;
                m_dv = 1'b0; m_par = 1'b0; m_stp = 1'b0; m_len = 0; m_data = 8'h00;
            end
            if (Data_Valid) begin
                if (m_len == 0) m_data = P_DATA;
                else if (P_DATA !== m_data) unstable_cnt++;
                m_len++;
                m_dv = 1'b1;
            end
            m_par = m_par | PAR_Err;
            m_stp = m_stp | STP_Err;
        end else if (m_active) begin
            m_active = 1'b0;
            n_episodes++;
            check("exp_available", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                m_exp = exp_q.pop_front();
                check("data_valid", 32'(m_dv), 32'(m_exp.dv));
                check("par_err", 32'(m_par), 32'(m_exp.par));
                check("stp_err", 32'(m_stp), 32'(m_exp.stp));
                check("dv_len", 32'(m_len), 32'(m_exp.dv_len));
                if (m_exp.dv) begin
                    check("p_data", 32'(m_data), 32'(m_exp.data));
                    check("p_data_hold", 32'(P_DATA), 32'(m_exp.data));
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (int'(Prescale)) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit, input int gap);
        exp_q.push_back(model(d, pen, ptyp, pbit, sbit, int'(Prescale)));
        Par_En  = pen;
        Par_Typ = ptyp;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        if (gap > 0) idle_cycles(gap);
    endtask

    task automatic random_frames(input int n, input int p, input bit with_errors);
        logic [7:0] d;
        logic pen, ptyp, pbit, sbit;
        Prescale = 6'(p);
        for (int k = 0; k < n; k++) begin
            d    = 8'($urandom_range(255));
            pen  = 1'($urandom_range(1));
            ptyp = 1'($urandom_range(1));
            pbit = good_par(d, ptyp);
            sbit = 1'b1;
            if (with_errors) begin
                if ($urandom_range(3) == 0) pbit = ~pbit;
                if ($urandom_range(3) == 0) sbit = 1'b0;
            end
            send_frame(d, pen, ptyp, pbit, sbit, int'($urandom_range(3, 1)));
        end
        idle_cycles(4);
    endtask

    int base_ep;
    int base_fc;

    initial begin
        RX_IN = 1'b1; Prescale = 6'd8; Par_En = 1'b0; Par_Typ = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(Data_Valid), 32'h0);
        check("rst_par", 32'(PAR_Err), 32'h0);
        check("rst_stp", 32'(STP_Err), 32'h0);
        rst = 1'b0;
        idle_cycles(5);

        // Directed frames
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 4);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle_cycles(10);

        // Short low pulse on the line
        base_ep = n_episodes;
        base_fc = flag_cycles;
        RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_cycles(40);
        check("glitch_flags", 32'(flag_cycles - base_fc), 32'd0);
        check("glitch_episodes", 32'(n_episodes - base_ep), 32'd0);
        check("glitch_hold", 32'(P_DATA), 32'h55);

        // Long idle
        base_fc = flag_cycles;
        idle_cycles(800);
        check("idle_flags", 32'(flag_cycles - base_fc), 32'd0);

        // Reset in the middle of a frame
        base_ep = n_episodes;
        Par_En = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        #2;
        check("midrst_p_data", 32'(P_DATA), 32'h0);
        check("midrst_flags", 32'({Data_Valid, PAR_Err, STP_Err}), 32'h0);
        RX_IN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(100);
        check("midrst_episodes", 32'(n_episodes - base_ep), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0, good_par(8'hC3, 1'b0), 1'b1, 4);

        // Randomized frames
        random_frames(30, 8, 1'b1);
        random_frames(100, 16, 1'b0);
        random_frames(100, 32, 1'b0);

        idle_cycles(60);
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        check("dv_with_err", 32'(overlap_cnt), 32'd0);
        check("p_data_stable", 32'(unstable_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
